// File: rtl/gpa_fhdo_feeder_pkg.sv
// Shared definitions for the GPA-FHDO feeder and SPI serialiser:
// command word field positions, FSM state encoding and default timing.
package gpa_fhdo_feeder_pkg;

    // Command word layout; payload [23:0], broadcast [24], channel [26:25],
    // reserved [31:27]. The feeder forwards words untouched.
    localparam int WORD_W      = 32;
    localparam int PAYLOAD_MSB = 23;
    localparam int BCAST_BIT   = 24;
    localparam int CHAN_LSB    = 25;
    localparam int CHAN_MSB    = 26;

    // Default timing and buffering.
    localparam int DEFAULT_BUSY_TIMEOUT = 128;
    localparam int DEFAULT_FIFO_AW      = 3;

    // Issue FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/gpa_fhdo_fifo.sv
// Single-clock FIFO with first-word-fall-through output. Writes while full
// and reads while empty are ignored. Occupancy is kept in its own counter so
// that a full FIFO is distinguishable from an empty one.
module gpa_fhdo_fifo #(
    parameter int AW = 3,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);

    localparam int            LW      = AW + 1;
    localparam int            DEPTH_I = 1 << AW;
    localparam logic [AW:0]   DEPTH   = DEPTH_I[AW:0];

    logic [DW-1:0] mem [DEPTH_I];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == DEPTH);
    assign empty = (level == '0);
    assign wr_en = wr && !full;
    assign rd_en = rd && !empty;
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo depth; level moves only on unmatched write/read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/gpa_fhdo_feeder.sv
// GPA-FHDO feeder: buffers DAC command words from the gradient memory core
// and hands them to the SPI serialiser one at a time, waiting for the
// serialiser's busy flag to rise and fall between words.
// Optional build macro GPA_FHDO_FEEDER_STATS_EN adds saturating words-sent /
// words-dropped counters.
module gpa_fhdo_feeder
    import gpa_fhdo_feeder_pkg::*;
#(
    parameter int FIFO_AW      = DEFAULT_FIFO_AW,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   data_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [WORD_W-1:0]   data_o,
    output logic                valid_o,
    input  logic                busy_i,
    input  logic                clear_i,
    output logic [FIFO_AW:0]    fifo_level_o,
    output logic                overflow_o,
    output logic                timeout_o,
`ifdef GPA_FHDO_FEEDER_STATS_EN
    output logic [31:0]         words_sent_o,
    output logic [15:0]         words_dropped_o,
`endif
    output logic                idle_o
);

    localparam int            TW         = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int            TMO_LAST_I = BUSY_TIMEOUT - 1;
    localparam logic [TW-1:0] TMO_LAST   = TMO_LAST_I[TW-1:0];

    feeder_state_t     state;
    feeder_state_t     state_next;
    logic [TW-1:0]     tmo_ctr;
    logic              pop;
    logic              tmo_evt;
    logic              ovf_evt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_dout;

    gpa_fhdo_fifo #(
        .AW (FIFO_AW),
        .DW (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (valid_i),
        .rd    (pop),
        .din   (data_i),
        .dout  (fifo_dout),
        .level (fifo_level_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A write into a full FIFO is lost even if a pop frees a slot this cycle.
    assign ready_o = !fifo_full;
    assign ovf_evt = valid_i && fifo_full;
    assign idle_o  = fifo_empty && (state == ST_IDLE) && !busy_i;

    // Next-state logic; the !busy_i guard in IDLE also covers a serialiser
    // that is still busy from before a reset.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tmo_evt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !busy_i) begin
                    state_next = ST_ISSUE;
                    pop        = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (busy_i) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_ctr == TMO_LAST) begin
                    state_next = ST_IDLE;
                    tmo_evt    = 1'b1;
                end else begin
                    state_next = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_i) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, issue pulse, held output word and busy-wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
            data_o  <= '0;
            tmo_ctr <= '0;
        end else begin
            state   <= state_next;
            valid_o <= (state_next == ST_ISSUE);
            if (pop) begin
                data_o <= fifo_dout;
            end
            if (state == ST_WAIT_BUSY) begin
                tmo_ctr <= tmo_ctr + TW'(1);
            end else begin
                tmo_ctr <= '0;
            end
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            overflow_o <= ovf_evt || (overflow_o && !clear_i);
            timeout_o  <= tmo_evt || (timeout_o && !clear_i);
        end
    end

`ifdef GPA_FHDO_FEEDER_STATS_EN
    localparam logic [31:0] SENT_MAX = 32'hFFFF_FFFF;
    localparam logic [15:0] DROP_MAX = 16'hFFFF;

    logic [1:0]  drop_inc;
    logic [15:0] drop_inc_w;
    logic [15:0] drop_room;

    assign drop_inc   = {1'b0, ovf_evt} + {1'b0, tmo_evt};
    assign drop_inc_w = {14'd0, drop_inc};
    assign drop_room  = DROP_MAX - words_dropped_o;

    // Saturating statistics; clear_i restarts both counts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_sent_o    <= 32'd0;
            words_dropped_o <= 16'd0;
        end else if (clear_i) begin
            words_sent_o    <= 32'd0;
            words_dropped_o <= 16'd0;
        end else begin
            if (valid_o && (words_sent_o != SENT_MAX)) begin
                words_sent_o <= words_sent_o + 32'd1;
            end
            if (drop_room < drop_inc_w) begin
                words_dropped_o <= DROP_MAX;
            end else begin
                words_dropped_o <= words_dropped_o + drop_inc_w;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpa_fhdo_feeder.sv
// Directed bench for gpa_fhdo_feeder: table-driven write vectors plus
// hand-written sequences for timeout and mid-transfer reset. A behavioural
// serialiser raises busy 3 cycles after each pulse and holds it 24 cycles.
module tb_gpa_fhdo_feeder;

    localparam int AW  = 3;
    localparam int TMO = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        busy_i;
    logic        clear_i;
    logic [AW:0] fifo_level_o;
    logic        overflow_o;
    logic        timeout_o;
    logic        idle_o;
`ifdef GPA_FHDO_FEEDER_STATS_EN
    logic [31:0] words_sent_o;
    logic [15:0] words_dropped_o;
`endif

    gpa_fhdo_feeder #(
        .FIFO_AW      (AW),
        .BUSY_TIMEOUT (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_i          (data_i),
        .valid_i         (valid_i),
        .ready_o         (ready_o),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .busy_i          (busy_i),
        .clear_i         (clear_i),
        .fifo_level_o    (fifo_level_o),
        .overflow_o      (overflow_o),
        .timeout_o       (timeout_o),
`ifdef GPA_FHDO_FEEDER_STATS_EN
        .words_sent_o    (words_sent_o),
        .words_dropped_o (words_dropped_o),
`endif
        .idle_o          (idle_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic        exp_ready;   // ready_o before the write
        logic [AW:0] exp_level;   // fifo_level_o after the write edge
        logic [31:0] exp_dout;    // word expected on data_o when issued
    } vec_t;

    vec_t        vecs[13];
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          pulses  = 0;
    int          lvl_max = 0;
    bit          auto_busy = 1'b0;
    int          dly  = 0;
    int          hold = 0;
    bit          prev_valid = 1'b0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pulse monitor and behavioural serialiser busy model.
    initial begin
        forever begin
            @(negedge clk);
            if (int'(fifo_level_o) > lvl_max) lvl_max = int'(fifo_level_o);
            if (valid_o === 1'b1) begin
                pulses++;
                chk("pulse_while_busy", {31'd0, busy_i}, 32'd0);
                chk("pulse_width", {31'd0, prev_valid}, 32'd0);
                chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("issue_data", data_o, exp_q.pop_front());
            end
            prev_valid = (valid_o === 1'b1);
            if (auto_busy) begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        busy_i = 1'b1;
                        hold   = 24;
                    end
                end else if (hold > 0) begin
                    hold--;
                    if (hold == 0) busy_i = 1'b0;
                end
                if (valid_o === 1'b1) dly = 3;
            end
        end
    end

    // Apply a run of table vectors on consecutive cycles.
    task automatic apply_vecs(input int first, input int n, input string tag);
        for (int i = first; i < first + n; i++) begin
            chk({tag, "_ready"}, {31'd0, ready_o}, {31'd0, vecs[i].exp_ready});
            data_i  = vecs[i].din;
            valid_i = 1'b1;
            if (vecs[i].exp_ready) exp_q.push_back(vecs[i].exp_dout);
            @(negedge clk);
            chk({tag, "_level"}, {28'd0, fifo_level_o}, {28'd0, vecs[i].exp_level});
        end
        valid_i = 1'b0;
    endtask

    // Wait (bounded) for all traffic to settle with the given pulse total.
    task automatic wait_quiet(input int want, input string tag);
        for (int c = 0; c < 800; c++) begin
            if (pulses == want && busy_i == 1'b0 && dly == 0 && idle_o === 1'b1) break;
            @(negedge clk);
        end
        chk({tag, "_pulses"}, pulses, want);
        chk({tag, "_idle"}, {31'd0, idle_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst     = 1'b1;
        data_i  = 32'd0;
        valid_i = 1'b0;
        busy_i  = 1'b0;
        clear_i = 1'b0;

        // Burst on ch0..3: first word is popped the cycle after it lands.
        vecs[0] = '{32'h0000_0100, 1'b1, 4'd1, 32'h0000_0100};
        vecs[1] = '{32'h0200_0200, 1'b1, 4'd1, 32'h0200_0200};
        vecs[2] = '{32'h0400_0300, 1'b1, 4'd2, 32'h0400_0300};
        vecs[3] = '{32'h0600_0400, 1'b1, 4'd3, 32'h0600_0400};
        // Fill while busy: 8 accepted (reserved bits set), 9th dropped.
        for (int i = 0; i < 9; i++) begin
            vecs[4 + i].din       = 32'hF800_0000 | (32'(i) << 25) | 32'(i + 16);
            vecs[4 + i].exp_ready = (i < 8);
            vecs[4 + i].exp_level = (i < 8) ? 4'(i + 1) : 4'd8;
            vecs[4 + i].exp_dout  = vecs[4 + i].din;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_level", {28'd0, fifo_level_o}, 32'd0);
        chk("rst_overflow", {31'd0, overflow_o}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        chk("rst_idle", {31'd0, idle_o}, 32'd1);
        chk("rst_data", data_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single word, latency and idle return.
        auto_busy = 1'b1;
        data_i  = 32'h0200_1234;
        valid_i = 1'b1;
        exp_q.push_back(32'h0200_1234);
        @(negedge clk);
        valid_i = 1'b0;
        chk("t1_level_n", {28'd0, fifo_level_o}, 32'd1);
        chk("t1_valid_n", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        chk("t1_valid_n1", {31'd0, valid_o}, 32'd1);
        chk("t1_data", data_o, 32'h0200_1234);
        wait_quiet(1, "t1");
        chk("t1_data_held", data_o, 32'h0200_1234);

        // 2: back-to-back burst of four.
        lvl_max = 0;
        apply_vecs(0, 4, "t2");
        wait_quiet(5, "t2");
        chk("t2_level_peak", lvl_max, 3);

        // 3: fill to overflow while busy, set-wins clear, then drain.
        auto_busy = 1'b0;
        busy_i    = 1'b1;
        @(negedge clk);
        apply_vecs(4, 9, "t3");
        chk("t3_overflow", {31'd0, overflow_o}, 32'd1);
        valid_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        clear_i = 1'b0;
        chk("t3_set_wins", {31'd0, overflow_o}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("t3_cleared", {31'd0, overflow_o}, 32'd0);
        chk("t3_level_kept", {28'd0, fifo_level_o}, 32'd8);
        busy_i    = 1'b0;
        auto_busy = 1'b1;
        wait_quiet(13, "t3");

        // 4: busy never rises -> timeout, next word still issues.
        auto_busy = 1'b0;
        data_i  = 32'h0400_0ABC;
        valid_i = 1'b1;
        exp_q.push_back(32'h0400_0ABC);
        @(negedge clk);
        data_i  = 32'h0600_0DEF;
        exp_q.push_back(32'h0600_0DEF);
        @(negedge clk);
        valid_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (valid_o === 1'b1) break;
            @(negedge clk);
        end
        chk("t4_pulse_seen", {31'd0, valid_o}, 32'd1);
        repeat (TMO) @(posedge clk);
        @(negedge clk);
        chk("t4_timeout_early", {31'd0, timeout_o}, 32'd0);
        @(negedge clk);
        chk("t4_timeout", {31'd0, timeout_o}, 32'd1);
        auto_busy = 1'b1;
        wait_quiet(15, "t4");
        chk("t4_sticky", {31'd0, timeout_o}, 32'd1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("t4_cleared", {31'd0, timeout_o}, 32'd0);

        // 5: async reset in WAIT_DONE with three words queued.
        exp_q.push_back(32'h0000_5001);
        for (int i = 0; i < 4; i++) begin
            data_i  = 32'h0000_5001 + 32'(i);
            valid_i = 1'b1;
            @(negedge clk);
        end
        valid_i = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy_i == 1'b1) break;
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("t5_level_before", {28'd0, fifo_level_o}, 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_level", {28'd0, fifo_level_o}, 32'd0);
        chk("t5_rst_valid", {31'd0, valid_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        data_i  = 32'h0600_5005;
        valid_i = 1'b1;
        exp_q.push_back(32'h0600_5005);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_held_busy", {31'd0, busy_i}, 32'd1);
        chk("t5_held_level", {28'd0, fifo_level_o}, 32'd1);
        wait_quiet(17, "t5");

`ifdef GPA_FHDO_FEEDER_STATS_EN
        // 6: statistics after 8 sent and 1 overflow.
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        chk("t6_sent_clr", words_sent_o, 32'd0);
        chk("t6_drop_clr", {16'd0, words_dropped_o}, 32'd0);
        auto_busy = 1'b0;
        busy_i    = 1'b1;
        @(negedge clk);
        apply_vecs(4, 9, "t6");
        busy_i    = 1'b0;
        auto_busy = 1'b1;
        wait_quiet(25, "t6");
        chk("t6_sent", words_sent_o, 32'd8);
        chk("t6_dropped", {16'd0, words_dropped_o}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
